mb_sync_tx_sched: RTL

Source-clock-domain scheduler that shares one mb_sync instance between NREQ requesters. It arbitrates round-robin and drives mb_sync i_data/i_valid with a one-cycle valid pulse. It holds the data word stable for the minimum spacing mb_sync needs before the next transfer. It sits in the source domain directly upstream of mb_sync, and its o_data/o_valid connect to mb_sync i_data/i_valid.

---
 rtl/mb_sync_pkg.sv | 15 +
 rtl/mb_sync_tx_sched_rr_arbiter.sv | 35 +++
 rtl/mb_sync_tx_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/mb_sync_pkg.sv
// Shared types and sizing helpers for the mb_sync transmit scheduler.
package mb_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mb_sync_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr, wrapping.
module rr_arbiter
  import mb_sync_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned GW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [GW-1:0]   grant_idx,
  output logic            any_req
);

  always_comb begin
    int unsigned pos;
    logic [GW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = 32'(rr_ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = GW'(pos);
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mb_sync_tx_sched.sv
// Source-domain scheduler sharing one mb_sync among NREQ requesters:
// round-robin grant, one-cycle valid pulse, data held for GAP cycles after it.
module mb_sync_tx_sched
  import mb_sync_pkg::*;
#(
  parameter int unsigned NB   = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned GAP  = 10,
  localparam int unsigned GW  = idx_width(NREQ),
  localparam int unsigned CW  = idx_width(GAP - 1)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*NB-1:0]   i_req_data,
  output logic [NREQ-1:0]      o_req_ready,
  output logic [NB-1:0]        o_data,
  output logic                 o_valid,
  output logic [GW-1:0]        o_grant_id,
  output logic                 o_busy
);

  sched_state_t    state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NB-1:0]   data_d;
  logic [GW-1:0]   gid_d;
  logic            valid_d;

  logic [NREQ-1:0] grant;
  logic [GW-1:0]   grant_idx;
  logic            any_req;
  logic [NB-1:0]   sel_word;
  logic [GW-1:0]   next_ptr;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (i_req_valid),
    .rr_ptr    (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // One-hot word select driven by the arbiter grant.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sel_word = sel_word | (i_req_data[k*NB +: NB] & {NB{grant[k]}});
    end
  end

  assign next_ptr = (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + GW'(1);

  // Handshake is only offered while idle and enabled, never during reset.
  always_comb begin
    o_req_ready = '0;
    if (state_q == IDLE && i_enable && !i_reset) o_req_ready = grant;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = o_data;
    gid_d   = o_grant_id;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_enable && any_req) begin
          state_d = SEND;
          data_d  = sel_word;
          gid_d   = grant_idx;
          ptr_d   = next_ptr;
          valid_d = 1'b1;
        end
      end
      SEND: begin
        cnt_d   = CW'(GAP - 2);
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_grant_id <= '0;
      o_busy     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      o_data     <= data_d;
      o_valid    <= valid_d;
      o_grant_id <= gid_d;
      o_busy     <= (state_d != IDLE);
    end
  end

endmodule
